// File: rtl/moore_1010_pkg.sv
// Shared definitions for the 1010 Moore pattern detector: state width and
// the fixed state encoding.
package moore_1010_pkg;

  localparam int STATE_W = 3;

  // Each state is the longest prefix of 1010 matched so far.
  typedef enum logic [STATE_W-1:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

endpackage

// File: rtl/moore_1010_detector.sv
// Moore FSM that flags the serial pattern 1010, with a saturating detection
// counter. Define MOORE_1010_OVERLAP_EN for overlapping detection.
module moore_1010_detector
  import moore_1010_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  output logic               out,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   det_count
);

  state_t state;
  state_t next_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S0;
      det_count <= '0;
    end else begin
      state <= next_state;
      if (next_state == S4 && det_count != '1) begin
        det_count <= det_count + CNT_W'(1);
      end
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = S0;
    case (state)
      S0: next_state = in ? S1 : S0;
      S1: next_state = in ? S1 : S2;
      S2: next_state = in ? S3 : S0;
      S3: next_state = in ? S1 : S4;
`ifdef MOORE_1010_OVERLAP_EN
      // The trailing 10 of a hit is reused as the start of the next match.
      S4: next_state = in ? S3 : S0;
`else
      S4: next_state = in ? S1 : S0;
`endif
      default: next_state = S0;
    endcase
  end

  assign out     = (state == S4);
  assign state_o = state;

endmodule

// File: tb/tb_moore_1010_detector.sv
// Directed, table-driven bench for moore_1010_detector, plus hand-written
// sequences for async reset mid-pattern and counter saturation.
module tb_moore_1010_detector;

  logic       clk;
  logic       rst;
  logic       in;
  logic       out;
  logic [2:0] state_o;
  logic [7:0] det_count;
  logic       sat_out;
  logic [2:0] sat_state;
  logic [1:0] sat_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst_first;
    bit         in;
    logic [2:0] st;
    bit         o;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  moore_1010_detector #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .out      (out),
    .state_o  (state_o),
    .det_count(det_count)
  );

  moore_1010_detector #(.CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .out      (sat_out),
    .state_o  (sat_state),
    .det_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step(input bit b);
    in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic add(input bit r, input bit b, input logic [2:0] st, input bit o,
                     input logic [7:0] cnt);
    vecs.push_back('{rst_first: r, in: b, st: st, o: o, cnt: cnt});
  endtask

  initial begin
    rst = 1'b0;
    in  = 1'b0;

    // Basic stream 1,0,1,0,0,0,1,0,1,0
    add(1, 1, 3'd1, 0, 0); add(0, 0, 3'd2, 0, 0); add(0, 1, 3'd3, 0, 0);
    add(0, 0, 3'd4, 1, 1); add(0, 0, 3'd0, 0, 1); add(0, 0, 3'd0, 0, 1);
    add(0, 1, 3'd1, 0, 1); add(0, 0, 3'd2, 0, 1); add(0, 1, 3'd3, 0, 1);
    add(0, 0, 3'd4, 1, 2);
    // Overlap stream 1,0,1,0,1,0
    add(1, 1, 3'd1, 0, 0); add(0, 0, 3'd2, 0, 0); add(0, 1, 3'd3, 0, 0);
    add(0, 0, 3'd4, 1, 1);
`ifdef MOORE_1010_OVERLAP_EN
    add(0, 1, 3'd3, 0, 1); add(0, 0, 3'd4, 1, 2);
`else
    add(0, 1, 3'd1, 0, 1); add(0, 0, 3'd2, 0, 1);
`endif
    // Near misses 1,1,0,1,1,0,0,1,0,0
    add(1, 1, 3'd1, 0, 0); add(0, 1, 3'd1, 0, 0); add(0, 0, 3'd2, 0, 0);
    add(0, 1, 3'd3, 0, 0); add(0, 1, 3'd1, 0, 0); add(0, 0, 3'd2, 0, 0);
    add(0, 0, 3'd0, 0, 0); add(0, 1, 3'd1, 0, 0); add(0, 0, 3'd2, 0, 0);
    add(0, 0, 3'd0, 0, 0);

    // Reset state: immediately and after an edge with reset still held.
    #1;
    check("reset_out", out, 0);
    check("reset_state", state_o, 0);
    check("reset_count", det_count, 0);
    @(posedge clk);
    #1;
    check("reset_held_out", out, 0);
    check("reset_held_state", state_o, 0);
    check("reset_held_count", det_count, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      step(vecs[i].in);
      check($sformatf("vec%0d_state", i), state_o, vecs[i].st);
      check($sformatf("vec%0d_out", i), out, vecs[i].o);
      check($sformatf("vec%0d_count", i), det_count, vecs[i].cnt);
    end

    // Reset mid-operation: reach a detection, start a new partial match,
    // pull reset low between edges, then finish the pattern.
    do_reset();
    step(1); step(0); step(1); step(0);
    check("mid_pre_count", det_count, 1);
    step(0); step(1); step(0); step(1);
    check("mid_pre_state", state_o, 3);
    #3;
    rst = 1'b0;
    #1;
    check("mid_async_state", state_o, 0);
    check("mid_async_out", out, 0);
    check("mid_async_count", det_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0);
    check("mid_after_state", state_o, 0);
    check("mid_after_out", out, 0);
    check("mid_after_count", det_count, 0);

    // Saturation: five separated detections on the 2-bit counter.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1); step(0); step(1); step(0);
      check($sformatf("sat%0d_out", k), sat_out, 1);
      check($sformatf("sat%0d_count2", k), sat_count, (k > 3) ? 3 : k);
      check($sformatf("sat%0d_count8", k), det_count, k);
      step(0);
      check($sformatf("sat%0d_hold", k), sat_count, (k > 3) ? 3 : k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
